// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch redirect controller: flush, fetch redirect, halt/restart
// Optional prediction checking is enabled by defining BRANCH_PREDICT_CHECK_EN.
module branch_ctrl #(
  parameter int P_FLUSH_CYCLES = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iEXE_VALID,
  input  logic        iEXE_JUMP,
  input  logic        iEXE_NOT_JUMP,
  input  logic        iEXE_IB,
  input  logic        iEXE_IDTS,
  input  logic        iEXE_HALT,
  input  logic [31:0] iEXE_PC,
  input  logic [31:0] iEXE_BRANCH_ADDR,
  input  logic [31:0] iIDT_BASE,
`ifdef BRANCH_PREDICT_CHECK_EN
  input  logic        iEXE_PREDICT_TAKEN,
  input  logic [31:0] iEXE_PREDICT_ADDR,
`endif
  input  logic        iRESTART,
  output logic        oEXE_LOCK,
  output logic        oFLUSH,
  output logic        oREDIRECT_VALID,
  output logic [31:0] oREDIRECT_ADDR,
  input  logic        iREDIRECT_BUSY,
  output logic        oHALTED
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } stateT;

  localparam logic [3:0] LoadCount = 4'(P_FLUSH_CYCLES - 1);

  stateT       state, stateNext;
  logic [3:0]  count, countNext;
  logic [31:0] target, targetNext;
  logic        haltFlag, haltFlagNext;

  logic [31:0] pcPlus4;
  logic        decodeRedirect;
  logic        decodeHalt;
  logic [31:0] decodeTarget;

  assign pcPlus4 = iEXE_PC + 32'd4;

  // Strobe decode in priority order; only consulted while IDLE.
  always_comb begin
    decodeRedirect = 1'b0;
    decodeHalt     = 1'b0;
    decodeTarget   = 32'd0;
    if (iEXE_HALT) begin
      decodeRedirect = 1'b1;
      decodeHalt     = 1'b1;
      decodeTarget   = pcPlus4;
    end else if (iEXE_IB) begin
      decodeRedirect = 1'b1;
      decodeTarget   = iIDT_BASE;
    end else if (iEXE_IDTS) begin
      decodeRedirect = 1'b1;
      decodeTarget   = pcPlus4;
    end else if (iEXE_JUMP) begin
`ifdef BRANCH_PREDICT_CHECK_EN
      decodeRedirect = !iEXE_PREDICT_TAKEN || (iEXE_PREDICT_ADDR != iEXE_BRANCH_ADDR);
`else
      decodeRedirect = 1'b1;
`endif
      decodeTarget   = iEXE_BRANCH_ADDR;
    end else if (iEXE_NOT_JUMP) begin
`ifdef BRANCH_PREDICT_CHECK_EN
      decodeRedirect = iEXE_PREDICT_TAKEN;
      decodeTarget   = pcPlus4;
`else
      decodeRedirect = 1'b0;
`endif
    end
  end

  always_comb begin
    stateNext    = state;
    countNext    = count;
    targetNext   = target;
    haltFlagNext = haltFlag;
    case (state)
      IDLE: begin
        if (iEXE_VALID && decodeRedirect) begin
          stateNext    = FLUSH;
          countNext    = LoadCount;
          targetNext   = decodeTarget;
          haltFlagNext = decodeHalt;
        end
      end
      FLUSH: begin
        if (count == 4'd0) begin
          stateNext = haltFlag ? HALT : REDIRECT;
        end else begin
          countNext = count - 4'd1;
        end
      end
      HALT: begin
        if (iRESTART) begin
          stateNext    = REDIRECT;
          haltFlagNext = 1'b0;
        end
      end
      REDIRECT: begin
        if (!iREDIRECT_BUSY) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state    <= IDLE;
      count    <= 4'd0;
      target   <= 32'd0;
      haltFlag <= 1'b0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      target   <= targetNext;
      haltFlag <= haltFlagNext;
    end
  end

  assign oEXE_LOCK       = (state != IDLE);
  assign oFLUSH          = (state == FLUSH);
  assign oREDIRECT_VALID = (state == REDIRECT);
  assign oREDIRECT_ADDR  = (state == REDIRECT) ? target : 32'd0;
  assign oHALTED         = (state == HALT);

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl with randomized reference-model checks
// Prediction tests are compiled when BRANCH_PREDICT_CHECK_EN is defined.
module tb_branch_ctrl;

  localparam int P = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic valid = 1'b0, jump = 1'b0, notJump = 1'b0, ib = 1'b0, idts = 1'b0, halt = 1'b0;
  logic restart = 1'b0, busy = 1'b0;
  logic [31:0] pc = 32'd0, baddr = 32'd0, idtBase = 32'd0;
`ifdef BRANCH_PREDICT_CHECK_EN
  logic predTaken = 1'b0;
  logic [31:0] predAddr = 32'd0;
`endif
  logic lock, flush, rv, halted;
  logic [31:0] ra;

  int nChecks = 0;
  int nFails = 0;

  branch_ctrl #(.P_FLUSH_CYCLES(P)) dut (
    .iCLOCK(clk),
    .iRESET_SYNC(rst),
    .iEXE_VALID(valid),
    .iEXE_JUMP(jump),
    .iEXE_NOT_JUMP(notJump),
    .iEXE_IB(ib),
    .iEXE_IDTS(idts),
    .iEXE_HALT(halt),
    .iEXE_PC(pc),
    .iEXE_BRANCH_ADDR(baddr),
    .iIDT_BASE(idtBase),
`ifdef BRANCH_PREDICT_CHECK_EN
    .iEXE_PREDICT_TAKEN(predTaken),
    .iEXE_PREDICT_ADDR(predAddr),
`endif
    .iRESTART(restart),
    .oEXE_LOCK(lock),
    .oFLUSH(flush),
    .oREDIRECT_VALID(rv),
    .oREDIRECT_ADDR(ra),
    .iREDIRECT_BUSY(busy),
    .oHALTED(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: what a single sampled result should do. s = {halt, ib, idts, jump, notJump}.
  function automatic void model(input logic v, input logic [4:0] s, input logic [31:0] p,
                                input logic [31:0] b, input logic [31:0] t,
                                output logic r, output logic [31:0] a, output logic h);
    r = 1'b0; a = 32'd0; h = 1'b0;
    if (v) begin
      if (s[4]) begin r = 1'b1; h = 1'b1; a = p + 32'd4; end
      else if (s[3]) begin r = 1'b1; a = t; end
      else if (s[2]) begin r = 1'b1; a = p + 32'd4; end
      else if (s[1]) begin
`ifdef BRANCH_PREDICT_CHECK_EN
        r = !predTaken || (predAddr != b);
`else
        r = 1'b1;
`endif
        a = b;
      end else if (s[0]) begin
`ifdef BRANCH_PREDICT_CHECK_EN
        r = predTaken;
        a = p + 32'd4;
`endif
      end
    end
  endfunction

  // Presents one result for one sampling edge, then clears the strobes.
  task automatic issue(input logic v, input logic [4:0] s, input logic [31:0] p,
                       input logic [31:0] b, input logic [31:0] t);
    valid = v;
    {halt, ib, idts, jump, notJump} = s;
    pc = p; baddr = b; idtBase = t;
    @(negedge clk);
    valid = 1'b0;
    {halt, ib, idts, jump, notJump} = 5'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL reset_lock got=%b exp=0", lock); end
    nChecks++; if (flush !== 1'b0) begin nFails++; $display("FAIL reset_flush got=%b exp=0", flush); end
    nChecks++; if (rv !== 1'b0) begin nFails++; $display("FAIL reset_valid got=%b exp=0", rv); end
    nChecks++; if (ra !== 32'd0) begin nFails++; $display("FAIL reset_addr got=%h exp=0", ra); end
    nChecks++; if (halted !== 1'b0) begin nFails++; $display("FAIL reset_halted got=%b exp=0", halted); end
    rst = 1'b0;
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL restart_idle_lock got=%b exp=0", lock); end
  endtask

  task automatic test_jump;
    busy = 1'b0;
    issue(1'b1, 5'b00010, 32'h0000_0100, 32'h0000_1000, 32'h0);
    for (int i = 0; i < P; i++) begin
      nChecks++; if (flush !== 1'b1) begin nFails++; $display("FAIL jump_flush%0d got=%b exp=1", i, flush); end
      nChecks++; if (ra !== 32'd0) begin nFails++; $display("FAIL jump_flush_addr%0d got=%h exp=0", i, ra); end
      @(negedge clk);
    end
    nChecks++; if (rv !== 1'b1) begin nFails++; $display("FAIL jump_valid got=%b exp=1", rv); end
    nChecks++; if (ra !== 32'h0000_1000) begin nFails++; $display("FAIL jump_addr got=%h exp=00001000", ra); end
    @(negedge clk);
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL jump_lock_drop got=%b exp=0", lock); end
    nChecks++; if (rv !== 1'b0) begin nFails++; $display("FAIL jump_valid_drop got=%b exp=0", rv); end
  endtask

  task automatic test_priority;
    issue(1'b1, 5'b01010, 32'h0000_0300, 32'h0000_5000, 32'h0000_0200);
    repeat (P) @(negedge clk);
    nChecks++; if (ra !== 32'h0000_0200) begin nFails++; $display("FAIL prio_ib_addr got=%h exp=00000200", ra); end
    @(negedge clk);
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL prio_single got=%b exp=0", lock); end
    issue(1'b1, 5'b00110, 32'hFFFF_FFFC, 32'h0000_5000, 32'h0000_0200);
    repeat (P) @(negedge clk);
    nChecks++; if (ra !== 32'h0000_0000) begin nFails++; $display("FAIL prio_idts_wrap got=%h exp=00000000", ra); end
    @(negedge clk);
  endtask

  task automatic test_halt;
    issue(1'b1, 5'b10000, 32'h0000_0040, 32'h0000_9000, 32'h0);
    for (int i = 0; i < P; i++) begin
      nChecks++; if (flush !== 1'b1) begin nFails++; $display("FAIL halt_flush%0d got=%b exp=1", i, flush); end
      if (i == 0) restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      nChecks++; if (halted !== 1'b1) begin nFails++; $display("FAIL halt_held%0d got=%b exp=1", i, halted); end
      nChecks++; if (rv !== 1'b0) begin nFails++; $display("FAIL halt_no_redirect%0d got=%b exp=0", i, rv); end
      @(negedge clk);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    nChecks++; if (halted !== 1'b0) begin nFails++; $display("FAIL halt_release got=%b exp=0", halted); end
    nChecks++; if (rv !== 1'b1) begin nFails++; $display("FAIL halt_resume_valid got=%b exp=1", rv); end
    nChecks++; if (ra !== 32'h0000_0044) begin nFails++; $display("FAIL halt_resume_addr got=%h exp=00000044", ra); end
    @(negedge clk);
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL halt_done_lock got=%b exp=0", lock); end
  endtask

  task automatic test_busy;
    issue(1'b1, 5'b00010, 32'h0000_0010, 32'h0000_2468, 32'h0);
    repeat (P) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      nChecks++; if (rv !== 1'b1) begin nFails++; $display("FAIL busy_valid%0d got=%b exp=1", k, rv); end
      nChecks++; if (ra !== 32'h0000_2468) begin nFails++; $display("FAIL busy_addr%0d got=%h exp=00002468", k, ra); end
      busy = (k < 5);
      valid = (k < 5); jump = (k < 5); baddr = 32'h0000_7777;
      @(negedge clk);
    end
    valid = 1'b0; jump = 1'b0; busy = 1'b0;
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL busy_ignored_valid got=%b exp=0", lock); end
  endtask

  task automatic test_reset_mid_op;
    issue(1'b1, 5'b00010, 32'h0, 32'h0000_0ABC, 32'h0);
    @(negedge clk);
    nChecks++; if (flush !== 1'b1) begin nFails++; $display("FAIL rstflush_pre got=%b exp=1", flush); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nChecks++; if (flush !== 1'b0) begin nFails++; $display("FAIL rstflush_flush got=%b exp=0", flush); end
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL rstflush_lock got=%b exp=0", lock); end
    for (int i = 0; i < P + 3; i++) begin
      nChecks++; if (rv !== 1'b0) begin nFails++; $display("FAIL rstflush_redirect%0d got=%b exp=0", i, rv); end
      @(negedge clk);
    end
    busy = 1'b1;
    issue(1'b1, 5'b00010, 32'h0, 32'h0000_0DEF, 32'h0);
    repeat (P) @(negedge clk);
    nChecks++; if (rv !== 1'b1) begin nFails++; $display("FAIL rstredir_pre got=%b exp=1", rv); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nChecks++; if (rv !== 1'b0) begin nFails++; $display("FAIL rstredir_redirect%0d got=%b exp=0", i, rv); end
      @(negedge clk);
    end
  endtask

`ifdef BRANCH_PREDICT_CHECK_EN
  task automatic test_predict;
    predTaken = 1'b1;
    issue(1'b1, 5'b00001, 32'hFFFF_FFFC, 32'h0000_1234, 32'h0);
    repeat (P) @(negedge clk);
    nChecks++; if (rv !== 1'b1) begin nFails++; $display("FAIL pred_nj_valid got=%b exp=1", rv); end
    nChecks++; if (ra !== 32'h0) begin nFails++; $display("FAIL pred_nj_addr got=%h exp=00000000", ra); end
    @(negedge clk);
    predAddr = 32'h0000_4000;
    issue(1'b1, 5'b00010, 32'h0000_0020, 32'h0000_4000, 32'h0);
    nChecks++; if (flush !== 1'b0) begin nFails++; $display("FAIL pred_jump_noflush got=%b exp=0", flush); end
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL pred_jump_nolock got=%b exp=0", lock); end
    predTaken = 1'b0;
  endtask
`else
  task automatic test_not_jump;
    issue(1'b1, 5'b00001, 32'h0000_0080, 32'h0000_1234, 32'h0);
    nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL notjump_lock got=%b exp=0", lock); end
    nChecks++; if (flush !== 1'b0) begin nFails++; $display("FAIL notjump_flush got=%b exp=0", flush); end
  endtask
`endif

  task automatic test_random;
    logic v, er, eh;
    logic [4:0] s;
    logic [31:0] p, b, t, ea;
    int cnt, busyLen;
    for (int n = 0; n < 60; n++) begin
      v = ($urandom_range(0, 7) != 0);
      s = 5'($urandom);
      p = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : $urandom;
      b = $urandom;
      t = $urandom;
`ifdef BRANCH_PREDICT_CHECK_EN
      predTaken = 1'($urandom);
      predAddr = ($urandom_range(0, 1) == 1) ? b : $urandom;
`endif
      model(v, s, p, b, t, er, ea, eh);
      issue(v, s, p, b, t);
      if (!er) begin
        nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL rnd%0d_nolock got=%b exp=0", n, lock); end
      end else begin
        cnt = 0;
        while (flush === 1'b1 && cnt < 20) begin cnt++; @(negedge clk); end
        nChecks++; if (cnt != P) begin nFails++; $display("FAIL rnd%0d_flushlen got=%0d exp=%0d", n, cnt, P); end
        if (eh) begin
          nChecks++; if (halted !== 1'b1) begin nFails++; $display("FAIL rnd%0d_halted got=%b exp=1", n, halted); end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          restart = 1'b1;
          @(negedge clk);
          restart = 1'b0;
        end
        busyLen = $urandom_range(0, 3);
        for (int k = 0; k <= busyLen; k++) begin
          nChecks++; if (rv !== 1'b1) begin nFails++; $display("FAIL rnd%0d_valid%0d got=%b exp=1", n, k, rv); end
          nChecks++; if (ra !== ea) begin nFails++; $display("FAIL rnd%0d_addr%0d got=%h exp=%h", n, k, ra, ea); end
          busy = (k < busyLen);
          @(negedge clk);
        end
        busy = 1'b0;
        nChecks++; if (lock !== 1'b0) begin nFails++; $display("FAIL rnd%0d_done got=%b exp=0", n, lock); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_priority();
    test_halt();
    test_busy();
    test_reset_mid_op();
`ifdef BRANCH_PREDICT_CHECK_EN
    test_predict();
`else
    test_not_jump();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
